// File: rtl/buffer_dma_engine.sv
// Descriptor-driven DMA engine: in-order word reads from external memory into a credit-limited
// FIFO, drained into the buffer-map write port. Define GARUDA_DMA_ABORT_EN to add abort_i/DRAIN.
module buffer_dma_engine #(
  parameter int DATA_WIDTH = 32,
  parameter int ADDR_WIDTH = 32,
  parameter int LEN_WIDTH  = 16,
  parameter int FIFO_DEPTH = 8
) (
  input  logic                  clk_i,
  input  logic                  rst_ni,
  input  logic                  desc_valid_i,
  output logic                  desc_ready_o,
  input  logic [ADDR_WIDTH-1:0] desc_src_addr_i,
  input  logic [ADDR_WIDTH-1:0] desc_dst_addr_i,
  input  logic [LEN_WIDTH-1:0]  desc_len_i,
  output logic                  mem_req_valid_o,
  input  logic                  mem_req_ready_i,
  output logic [ADDR_WIDTH-1:0] mem_req_addr_o,
  input  logic                  mem_rsp_valid_i,
  input  logic [DATA_WIDTH-1:0] mem_rsp_data_i,
  output logic                  dma_wr_valid_o,
  output logic [ADDR_WIDTH-1:0] dma_wr_addr_o,
  output logic [DATA_WIDTH-1:0] dma_wr_data_o,
  input  logic                  dma_wr_ready_i,
`ifdef GARUDA_DMA_ABORT_EN
  input  logic                  abort_i,
`endif
  output logic                  busy_o,
  output logic                  done_o,
  output logic                  err_o
);

  localparam int PW    = $clog2(FIFO_DEPTH);
  localparam int CW    = PW + 1;
  localparam int BYTES = DATA_WIDTH / 8;
  localparam logic [ADDR_WIDTH:0] WGT_END  = (ADDR_WIDTH+1)'(32'h0001_FFFF);
  localparam logic [ADDR_WIDTH:0] PING_END = (ADDR_WIDTH+1)'(32'h0002_FFFF);
  localparam logic [ADDR_WIDTH:0] PONG_END = (ADDR_WIDTH+1)'(32'h0003_FFFF);
  localparam logic [ADDR_WIDTH:0] ACC_END  = (ADDR_WIDTH+1)'(32'h0004_7FFF);
  localparam logic [2:0]          NO_REGION = 3'd7;

`ifdef GARUDA_DMA_ABORT_EN
  typedef enum logic [1:0] {S_IDLE = 2'd0, S_RUN = 2'd1, S_DRAIN = 2'd2, S_DONE = 2'd3} state_t;
`else
  typedef enum logic [1:0] {S_IDLE = 2'd0, S_RUN = 2'd1, S_DONE = 2'd3} state_t;
`endif

  state_t                r_state, w_state_next;
  logic [ADDR_WIDTH-1:0] r_src, r_dst;
  logic [LEN_WIDTH-1:0]  r_len, r_req_cnt, r_wr_cnt;
  logic [CW-1:0]         r_inflight, r_count;
  logic [PW-1:0]         r_wr_ptr, r_rd_ptr;
  logic                  r_err;
  logic [DATA_WIDTH-1:0] r_fifo_mem [FIFO_DEPTH];

  logic [ADDR_WIDTH:0]   w_dst_start, w_dst_end;
  logic                  w_desc_ok, w_desc_fire, w_req_fire, w_wr_fire, w_last_wr;
  logic                  w_rsp_ok, w_push, w_flush, w_set_err;

  // Regions are contiguous, so both span endpoints in the same region means the whole span is.
  function automatic logic [2:0] region_of(input logic [ADDR_WIDTH:0] a);
    if (a <= WGT_END)       region_of = 3'd0;
    else if (a <= PING_END) region_of = 3'd1;
    else if (a <= PONG_END) region_of = 3'd2;
    else if (a <= ACC_END)  region_of = 3'd3;
    else                    region_of = NO_REGION;
  endfunction

  assign w_dst_start = {1'b0, desc_dst_addr_i};
  assign w_dst_end   = w_dst_start + (ADDR_WIDTH+1)'(desc_len_i) - (ADDR_WIDTH+1)'(1);
  assign w_desc_ok   = (desc_len_i != '0) && (region_of(w_dst_start) != NO_REGION) &&
                       (region_of(w_dst_start) == region_of(w_dst_end));

  assign desc_ready_o    = (r_state == S_IDLE);
  assign w_desc_fire     = desc_valid_i && desc_ready_o;
  assign mem_req_valid_o = (r_state == S_RUN) && (r_req_cnt < r_len) &&
                           (({1'b0, r_inflight} + {1'b0, r_count}) < (CW+1)'(FIFO_DEPTH));
  assign mem_req_addr_o  = mem_req_valid_o ?
                           r_src + ADDR_WIDTH'(r_req_cnt) * ADDR_WIDTH'(BYTES) : '0;
  assign w_req_fire      = mem_req_valid_o && mem_req_ready_i;

  // Responses with nothing outstanding are protocol violations and are dropped.
  assign w_rsp_ok        = mem_rsp_valid_i && (r_inflight != '0);
  assign w_push          = w_rsp_ok && (r_state == S_RUN) && !w_flush;

  assign dma_wr_valid_o  = (r_state == S_RUN) && (r_count != '0);
  assign dma_wr_addr_o   = dma_wr_valid_o ? r_dst + ADDR_WIDTH'(r_wr_cnt) : '0;
  assign dma_wr_data_o   = dma_wr_valid_o ? r_fifo_mem[r_rd_ptr] : '0;
  assign w_wr_fire       = dma_wr_valid_o && dma_wr_ready_i;
  assign w_last_wr       = (r_wr_cnt + LEN_WIDTH'(1)) == r_len;

  assign busy_o = (r_state != S_IDLE);
  assign done_o = (r_state == S_DONE);
  assign err_o  = r_err;

  always_comb begin
    w_state_next = r_state;
    w_flush      = 1'b0;
    w_set_err    = 1'b0;
    case (r_state)
      S_IDLE: if (desc_valid_i) w_state_next = w_desc_ok ? S_RUN : S_DONE;
      S_RUN: begin
`ifdef GARUDA_DMA_ABORT_EN
        if (abort_i) begin
          w_state_next = S_DRAIN;
          w_flush      = 1'b1;
        end else
`endif
        if (w_wr_fire && w_last_wr) w_state_next = S_DONE;
      end
`ifdef GARUDA_DMA_ABORT_EN
      S_DRAIN: begin
        w_flush = 1'b1;
        if (r_inflight == '0) begin
          w_state_next = S_DONE;
          w_set_err    = 1'b1;
        end
      end
`endif
      S_DONE:  w_state_next = S_IDLE;
      default: w_state_next = S_IDLE;
    endcase
  end

  always_ff @(posedge clk_i or negedge rst_ni) begin
    if (!rst_ni) begin
      r_state    <= S_IDLE;
      r_src      <= '0;
      r_dst      <= '0;
      r_len      <= '0;
      r_req_cnt  <= '0;
      r_wr_cnt   <= '0;
      r_inflight <= '0;
      r_count    <= '0;
      r_wr_ptr   <= '0;
      r_rd_ptr   <= '0;
      r_err      <= 1'b0;
    end else begin
      r_state <= w_state_next;
      if (w_desc_fire) begin
        r_src     <= desc_src_addr_i;
        r_dst     <= desc_dst_addr_i;
        r_len     <= desc_len_i;
        r_req_cnt <= '0;
        r_wr_cnt  <= '0;
        r_err     <= !w_desc_ok;
      end else begin
        if (w_req_fire) r_req_cnt <= r_req_cnt + LEN_WIDTH'(1);
        if (w_wr_fire)  r_wr_cnt  <= r_wr_cnt + LEN_WIDTH'(1);
        if (w_set_err)  r_err     <= 1'b1;
      end
      case ({w_req_fire, w_rsp_ok})
        2'b10:   r_inflight <= r_inflight + CW'(1);
        2'b01:   r_inflight <= r_inflight - CW'(1);
        default: r_inflight <= r_inflight;
      endcase
      if (w_flush) begin
        r_wr_ptr <= '0;
        r_rd_ptr <= '0;
        r_count  <= '0;
      end else begin
        if (w_push)    r_wr_ptr <= r_wr_ptr + PW'(1);
        if (w_wr_fire) r_rd_ptr <= r_rd_ptr + PW'(1);
        case ({w_push, w_wr_fire})
          2'b10:   r_count <= r_count + CW'(1);
          2'b01:   r_count <= r_count - CW'(1);
          default: r_count <= r_count;
        endcase
      end
    end
  end

  // Storage is left unreset; the head is masked to zero whenever the FIFO is empty.
  always_ff @(posedge clk_i) begin
    if (w_push) r_fifo_mem[r_wr_ptr] <= mem_rsp_data_i;
  end

endmodule

// File: tb/tb_buffer_dma_engine.sv
// Scoreboard bench for buffer_dma_engine: randomized descriptors, a latency-modelled memory and
// a reference model of the expected read/write streams and completion status.
module tb_buffer_dma_engine;
  localparam int DW = 32;
  localparam int AW = 32;
  localparam int LW = 16;
  localparam int FD = 8;

  logic          clk = 1'b0;
  logic          rst_ni = 1'b0;
  logic          desc_valid_i = 1'b0;
  logic          desc_ready_o;
  logic [AW-1:0] desc_src_addr_i = '0;
  logic [AW-1:0] desc_dst_addr_i = '0;
  logic [LW-1:0] desc_len_i = '0;
  logic          mem_req_valid_o;
  logic          mem_req_ready_i = 1'b0;
  logic [AW-1:0] mem_req_addr_o;
  logic          mem_rsp_valid_i = 1'b0;
  logic [DW-1:0] mem_rsp_data_i = '0;
  logic          dma_wr_valid_o;
  logic [AW-1:0] dma_wr_addr_o;
  logic [DW-1:0] dma_wr_data_o;
  logic          dma_wr_ready_i = 1'b0;
  logic          busy_o, done_o, err_o;
`ifdef GARUDA_DMA_ABORT_EN
  logic          abort_i = 1'b0;
`endif

  buffer_dma_engine #(.DATA_WIDTH(DW), .ADDR_WIDTH(AW), .LEN_WIDTH(LW), .FIFO_DEPTH(FD)) dut (
    .clk_i(clk), .rst_ni(rst_ni),
    .desc_valid_i(desc_valid_i), .desc_ready_o(desc_ready_o),
    .desc_src_addr_i(desc_src_addr_i), .desc_dst_addr_i(desc_dst_addr_i), .desc_len_i(desc_len_i),
    .mem_req_valid_o(mem_req_valid_o), .mem_req_ready_i(mem_req_ready_i),
    .mem_req_addr_o(mem_req_addr_o),
    .mem_rsp_valid_i(mem_rsp_valid_i), .mem_rsp_data_i(mem_rsp_data_i),
    .dma_wr_valid_o(dma_wr_valid_o), .dma_wr_addr_o(dma_wr_addr_o),
    .dma_wr_data_o(dma_wr_data_o), .dma_wr_ready_i(dma_wr_ready_i),
`ifdef GARUDA_DMA_ABORT_EN
    .abort_i(abort_i),
`endif
    .busy_o(busy_o), .done_o(done_o), .err_o(err_o)
  );

  always #5 clk = ~clk;

  typedef struct packed {logic [31:0] addr; logic [31:0] data; logic first; logic last;} wr_t;
  typedef struct {int due; logic [31:0] data;} rsp_t;

  wr_t         exp_wr_q[$];
  logic [31:0] exp_req_q[$];
  logic        exp_done_q[$];
  rsp_t        rsp_q[$];

  int checks = 0, errors = 0;
  int cyc = 0;
  int lat = 2;
  bit req_rdy_always = 1'b1;
  int wr_mode = 1;            // 0 random, 1 always ready, 2 held low
  int done_cnt = 0;
  int first_wr_cyc = 0, last_wr_cyc = 0;
  bit cur_ok;
  int cur_done_base;

  task automatic chk(input string name, input logic [63:0] act, input logic [63:0] req);
    checks++;
    if (act !== req) begin
      errors++;
      $display("FAIL %s actual=%0h required=%0h (cycle %0d)", name, act, req, cyc);
    end
  endtask

  function automatic logic [31:0] mem_fn(input logic [31:0] a);
    return (a * 32'h9E37_79B1) ^ 32'h5A5A_0F0F;
  endfunction

  function automatic bit legal(input logic [31:0] dst, input int len);
    longint lo[4] = '{64'h0, 64'h2_0000, 64'h3_0000, 64'h4_0000};
    longint hi[4] = '{64'h1_FFFF, 64'h2_FFFF, 64'h3_FFFF, 64'h4_7FFF};
    longint s, e;
    if (len == 0) return 1'b0;
    s = {32'b0, dst};
    e = s + len - 1;
    for (int i = 0; i < 4; i++) if (s >= lo[i] && e <= hi[i]) return 1'b1;
    return 1'b0;
  endfunction

  // Memory model and ready generation: inputs change on the falling edge.
  initial begin
    forever begin
      @(negedge clk);
      cyc++;
      if (!rst_ni) begin
        rsp_q.delete();
        mem_rsp_valid_i = 1'b0;
        mem_req_ready_i = 1'b0;
        dma_wr_ready_i  = 1'b0;
        continue;
      end
      mem_req_ready_i = req_rdy_always ? 1'b1 : ($urandom_range(0, 3) != 0);
      case (wr_mode)
        0:       dma_wr_ready_i = ($urandom_range(0, 3) != 0);
        1:       dma_wr_ready_i = 1'b1;
        default: dma_wr_ready_i = 1'b0;
      endcase
      if (rsp_q.size() > 0 && rsp_q[0].due <= cyc) begin
        mem_rsp_valid_i = 1'b1;
        mem_rsp_data_i  = rsp_q[0].data;
        void'(rsp_q.pop_front());
      end else begin
        mem_rsp_valid_i = 1'b0;
        mem_rsp_data_i  = $urandom;
      end
      if (mem_req_valid_o && mem_req_ready_i)
        rsp_q.push_back('{cyc + lat, mem_fn(mem_req_addr_o)});
    end
  end

  // Monitor: pops expectations whenever the DUT presents a handshake or completion.
  initial begin
    int req_tot = 0, wr_tot = 0;
    bit prev_done = 1'b0;
    forever begin
      @(negedge clk);
      #2;
      if (!rst_ni) begin
        req_tot = 0;
        wr_tot = 0;
        prev_done = 1'b0;
        continue;
      end
      if (mem_req_valid_o && mem_req_ready_i) begin
        chk("credit_limit", 64'((req_tot - wr_tot) < FD), 64'd1);
        if (exp_req_q.size() == 0) chk("unexpected_req", {32'b0, mem_req_addr_o}, 64'hFFFF_FFFF_FFFF_FFFF);
        else chk("req_addr", {32'b0, mem_req_addr_o}, {32'b0, exp_req_q.pop_front()});
      end
      if (dma_wr_valid_o && dma_wr_ready_i) begin
        if (exp_wr_q.size() == 0) begin
          chk("unexpected_wr", {32'b0, dma_wr_addr_o}, 64'hFFFF_FFFF_FFFF_FFFF);
        end else begin
          wr_t e;
          e = exp_wr_q.pop_front();
          chk("wr_addr", {32'b0, dma_wr_addr_o}, {32'b0, e.addr});
          chk("wr_data", {32'b0, dma_wr_data_o}, {32'b0, e.data});
          if (e.first) first_wr_cyc = cyc;
          if (e.last)  last_wr_cyc  = cyc;
        end
      end
      if (mem_req_valid_o && mem_req_ready_i) req_tot++;
      if (dma_wr_valid_o && dma_wr_ready_i)   wr_tot++;
      if (prev_done) begin
        chk("busy_after_done", {63'b0, busy_o}, 64'd0);
        chk("ready_after_done", {63'b0, desc_ready_o}, 64'd1);
      end
      if (done_o) begin
        if (exp_done_q.size() == 0) begin
          chk("unexpected_done", 64'd1, 64'd0);
        end else begin
          logic e_err;
          e_err = exp_done_q.pop_front();
          chk("done_err", {63'b0, err_o}, {63'b0, e_err});
          if (!e_err) chk("done_latency", 64'(cyc), 64'(last_wr_cyc + 1));
        end
        done_cnt++;
      end
      prev_done = done_o;
    end
  end

  task automatic issue_desc(input logic [31:0] src, input logic [31:0] dst, input int len);
    int t;
    cur_ok = legal(dst, len);
    @(negedge clk);
    desc_valid_i = 1'b1;
    desc_src_addr_i = src;
    desc_dst_addr_i = dst;
    desc_len_i = 16'(len);
    t = 0;
    while (!desc_ready_o && t < 100) begin
      @(negedge clk);
      t++;
    end
    chk("desc_ready", {63'b0, desc_ready_o}, 64'd1);
    if (cur_ok) begin
      for (int i = 0; i < len; i++) begin
        exp_req_q.push_back(src + 32'(4 * i));
        exp_wr_q.push_back('{dst + 32'(i), mem_fn(src + 32'(4 * i)), i == 0, i == len - 1});
      end
    end
    exp_done_q.push_back(!cur_ok);
    cur_done_base = done_cnt;
    @(negedge clk);
    desc_valid_i = 1'b0;
    desc_src_addr_i = $urandom;
    desc_dst_addr_i = $urandom;
    desc_len_i = 16'($urandom);
    #3;
    chk("busy_after_accept", {63'b0, busy_o}, 64'd1);
    if (cur_ok) chk("err_cleared", {63'b0, err_o}, 64'd0);
    else chk("err_done_immediate", {62'b0, done_o, err_o}, 64'd3);
  endtask

  task automatic wait_done(input int max_cyc);
    int t;
    t = 0;
    while (done_cnt == cur_done_base && t < max_cyc) begin
      @(negedge clk);
      #3;
      t++;
    end
    chk("done_seen", 64'(done_cnt > cur_done_base), 64'd1);
  endtask

  task automatic run_desc(input logic [31:0] src, input logic [31:0] dst, input int len);
    issue_desc(src, dst, len);
    wait_done(3000);
  endtask

  task automatic check_reset_outputs(input string tag);
    chk({tag, "_ready"}, {63'b0, desc_ready_o}, 64'd1);
    chk({tag, "_flags"}, {59'b0, mem_req_valid_o, dma_wr_valid_o, busy_o, done_o, err_o}, 64'd0);
    chk({tag, "_req_addr"}, {32'b0, mem_req_addr_o}, 64'd0);
    chk({tag, "_wr_addr"}, {32'b0, dma_wr_addr_o}, 64'd0);
    chk({tag, "_wr_data"}, {32'b0, dma_wr_data_o}, 64'd0);
  endtask

  initial begin
    repeat (3) @(negedge clk);
    #1;
    check_reset_outputs("reset_hold");
    rst_ni = 1'b1;
    @(negedge clk);
    #3;
    check_reset_outputs("reset_release");

    // Basic transfer, then the same source with the write side stalled for 20 cycles.
    lat = 2; req_rdy_always = 1'b1; wr_mode = 1;
    run_desc(32'h1000, 32'h0, 4);
    wr_mode = 2;
    issue_desc(32'h1000, 32'h0, 12);
    repeat (20) @(negedge clk);
    wr_mode = 1;
    wait_done(500);

    // Range violation at the accumulator end, zero length, then a clean descriptor.
    run_desc(32'h2000, 32'h4_7FFE, 4);
    run_desc(32'h2000, 32'h1_0000, 0);
    run_desc(32'h3000, 32'h3_FFFC, 4);

    // Streaming throughput: 64 back-to-back writes.
    run_desc(32'h8000, 32'h2_0000, 64);
    chk("throughput_span", 64'(last_wr_cyc - first_wr_cyc), 64'd63);

    // Randomized descriptors, readies and latency.
    req_rdy_always = 1'b0; wr_mode = 0;
    for (int n = 0; n < 14; n++) begin
      logic [31:0] dst, src;
      int len, r;
      logic [31:0] bases[5] = '{32'h0, 32'h2_0000, 32'h3_0000, 32'h4_0000, 32'h4_8000};
      logic [31:0] ends[5]  = '{32'h1_FFFF, 32'h2_FFFF, 32'h3_FFFF, 32'h4_7FFF, 32'h5_0000};
      lat = $urandom_range(1, 6);
      len = $urandom_range(0, 20);
      r = $urandom_range(0, 4);
      if ($urandom_range(0, 1) == 0) dst = ends[r] - 32'($urandom_range(0, 25));
      else dst = bases[r] + 32'($urandom_range(0, 255));
      src = {14'b0, 16'($urandom), 2'b00};
      run_desc(src, dst, len);
    end

    // Reset in the middle of a long transfer.
    lat = 3; req_rdy_always = 1'b1; wr_mode = 1;
    issue_desc(32'h4000, 32'h0_1000, 40);
    repeat (10) @(negedge clk);
    rst_ni = 1'b0;
    #1;
    check_reset_outputs("reset_mid");
    exp_req_q.delete();
    exp_wr_q.delete();
    exp_done_q.delete();
    repeat (3) @(negedge clk);
    rst_ni = 1'b1;
    run_desc(32'h5000, 32'h3_0010, 6);

    repeat (5) @(negedge clk);
    chk("queues_empty", 64'(exp_req_q.size() + exp_wr_q.size() + exp_done_q.size()), 64'd0);
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

  initial begin
    #2_000_000;
    $display("FAIL global_timeout actual=running required=finished");
    $fatal(1, "timeout");
  end
endmodule
